gpu_wb_arbiter: RTL and testbench

GPU_WB_ARBITER -- requirements
Module: gpu_wb_arbiter

---
 rtl/gpu_wb_arbiter.sv | 141 ++++++++++++++
 tb/tb_gpu_wb_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpu_wb_arbiter.sv
// Round-robin Wishbone arbiter: NUM_MASTERS GPU masters share one slave bus.
// A grant is held for the whole cycle (cyc high); a stalled strobe is aborted by an err pulse.

module gpu_wb_arbiter_port #(
    parameter int DATA_W = 32
) (
    input  logic              sel,
    input  logic              ack,
    input  logic              err,
    input  logic [DATA_W-1:0] dat,
    output logic              m_ack,
    output logic              m_err,
    output logic [DATA_W-1:0] m_dat
);
    assign m_ack = sel & ack;
    assign m_err = sel & err;
    assign m_dat = dat;
endmodule

module gpu_wb_arbiter #(
    parameter int NUM_MASTERS = 4,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT     = 255
) (
    input  logic                            clk_i,
    input  logic                            rst_n_i,
    input  logic [NUM_MASTERS*ADDR_W-1:0]   m_adr_i,
    input  logic [NUM_MASTERS*DATA_W-1:0]   m_dat_i,
    input  logic [NUM_MASTERS*DATA_W/8-1:0] m_sel_i,
    input  logic [NUM_MASTERS-1:0]          m_we_i,
    input  logic [NUM_MASTERS-1:0]          m_stb_i,
    input  logic [NUM_MASTERS-1:0]          m_cyc_i,
    output logic [NUM_MASTERS*DATA_W-1:0]   m_dat_o,
    output logic [NUM_MASTERS-1:0]          m_ack_o,
    output logic [NUM_MASTERS-1:0]          m_err_o,
    output logic [ADDR_W-1:0]               s_adr_o,
    output logic [DATA_W-1:0]               s_dat_o,
    output logic [DATA_W/8-1:0]             s_sel_o,
    output logic                            s_we_o,
    output logic                            s_stb_o,
    output logic                            s_cyc_o,
    input  logic [DATA_W-1:0]               s_dat_i,
    input  logic                            s_ack_i,
    output logic [NUM_MASTERS-1:0]          grant_o,
    output logic                            busy_o
);
    localparam int SEL_W = DATA_W / 8;
    localparam int IDX_W = $clog2(NUM_MASTERS);
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t           state, state_nxt;
    logic [IDX_W-1:0] gnt_idx, last_idx, winner;
    logic [CNT_W-1:0] wait_cnt;
    logic             busy, g_cyc, g_stb, timeout_hit, ack_pass;
    int               cand;

    assign busy  = (state == GRANT);
    assign g_cyc = m_cyc_i[gnt_idx];
    assign g_stb = m_stb_i[gnt_idx];

    // Scan downward so the closest requester after last_idx is the final assignment.
    always_comb begin
        winner = last_idx;
        cand   = 0;
        for (int i = NUM_MASTERS; i >= 1; i--) begin
            cand = (int'(last_idx) + i) % NUM_MASTERS;
            if (m_cyc_i[cand]) winner = IDX_W'(cand);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|m_cyc_i) state_nxt = GRANT;
            GRANT:   if (!g_cyc)   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state    <= IDLE;
            gnt_idx  <= '0;
            last_idx <= IDX_W'(NUM_MASTERS - 1);
        end else begin
            state <= state_nxt;
            if (state == IDLE && |m_cyc_i) begin
                gnt_idx  <= winner;
                last_idx <= winner;
            end
        end
    end

    generate
        if (TIMEOUT > 0) begin : g_timeout
            // Ack wins a tie with the limit: the transfer completed, nothing to abort.
            assign timeout_hit = busy && g_stb && !s_ack_i && (wait_cnt == CNT_W'(TIMEOUT));

            always_ff @(posedge clk_i or negedge rst_n_i) begin
                if (!rst_n_i)
                    wait_cnt <= '0;
                else if (!busy || !g_stb || s_ack_i || timeout_hit)
                    wait_cnt <= '0;
                else
                    wait_cnt <= wait_cnt + 1'b1;
            end
        end else begin : g_no_timeout
            assign timeout_hit = 1'b0;
            assign wait_cnt    = '0;
        end
    endgenerate

    // rst_n_i gating makes the bus drop combinationally on reset entry.
    assign s_cyc_o  = busy && rst_n_i && g_cyc && !timeout_hit;
    assign s_stb_o  = busy && rst_n_i && g_stb && !timeout_hit;
    assign s_we_o   = busy && rst_n_i && m_we_i[gnt_idx];
    assign s_adr_o  = busy ? m_adr_i[gnt_idx*ADDR_W +: ADDR_W] : '0;
    assign s_dat_o  = busy ? m_dat_i[gnt_idx*DATA_W +: DATA_W] : '0;
    assign s_sel_o  = busy ? m_sel_i[gnt_idx*SEL_W +: SEL_W]   : '0;
    assign ack_pass = s_ack_i && rst_n_i;
    assign busy_o   = busy;

    generate
        for (genvar k = 0; k < NUM_MASTERS; k++) begin : g_port
            assign grant_o[k] = busy && (gnt_idx == IDX_W'(k));

            gpu_wb_arbiter_port #(.DATA_W(DATA_W)) u_port (
                .sel   (grant_o[k]),
                .ack   (ack_pass),
                .err   (timeout_hit),
                .dat   (s_dat_i),
                .m_ack (m_ack_o[k]),
                .m_err (m_err_o[k]),
                .m_dat (m_dat_o[k*DATA_W +: DATA_W])
            );
        end
    endgenerate
endmodule

// File: tb/tb_gpu_wb_arbiter.sv
// Scoreboard bench for gpu_wb_arbiter: transaction-level round-robin model feeds
// expected grants/responses to queues; a negedge monitor pops and compares.

module tb_gpu_wb_arbiter;
    localparam int NM = 4, AW = 32, DW = 32, SW = DW / 8, TO = 8;
    localparam int RAND = 0, FIXED = 1, NEVER = 2;

    logic clk = 1'b0, rst_n = 1'b0;
    logic [NM*AW-1:0] m_adr;
    logic [NM*DW-1:0] m_wdat, m_dat_o;
    logic [NM*SW-1:0] m_sel;
    logic [NM-1:0]    m_we, m_stb, m_cyc, m_ack_o, m_err_o, grant_o;
    logic [AW-1:0]    s_adr_o;
    logic [DW-1:0]    s_dat_o, s_dat_i;
    logic [SW-1:0]    s_sel_o;
    logic             s_we_o, s_stb_o, s_cyc_o, s_ack_i, busy_o;

    gpu_wb_arbiter #(.NUM_MASTERS(NM), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .m_adr_i(m_adr), .m_dat_i(m_wdat), .m_sel_i(m_sel), .m_we_i(m_we),
        .m_stb_i(m_stb), .m_cyc_i(m_cyc),
        .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
        .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
        .grant_o(grant_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    typedef struct {logic [AW-1:0] adr; logic [DW-1:0] wdat; logic [SW-1:0] sel; logic we;} beat_t;
    typedef struct {int k; bit err; beat_t b;} ev_t;

    beat_t bq[NM][$];
    beat_t cur[NM];
    bit    active[NM];
    ev_t   ev_q[$];
    int    gr_q[$];
    int    ml = NM - 1;
    int    checks = 0, errors = 0;
    int    smode = RAND, lat = 0;
    bit    force_ack = 1'b0;
    logic [NM-1:0] samp_ack, samp_err;
    logic          samp_busy, samp_stb, samp_cyc;
    logic [DW-1:0] samp_dat1;

    function automatic logic [DW-1:0] sfun(logic [AW-1:0] a);
        return a ^ 32'h5A5A_5A5A;
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void drive_all();
        for (int k = 0; k < NM; k++) begin
            m_cyc[k]             = active[k];
            m_stb[k]             = active[k];
            m_we[k]              = active[k] ? cur[k].we : 1'b0;
            m_adr[k*AW +: AW]    = active[k] ? cur[k].adr : '0;
            m_wdat[k*DW +: DW]   = active[k] ? cur[k].wdat : '0;
            m_sel[k*SW +: SW]    = active[k] ? cur[k].sel : '0;
        end
    endfunction

    function automatic void queue_burst(int k, int n);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.adr = $urandom; b.wdat = $urandom; b.sel = SW'($urandom); b.we = 1'($urandom);
            bq[k].push_back(b);
        end
    endfunction

    // Reference arbitration: simultaneous requesters are served in rotation after the last winner.
    function automatic void plan(logic [NM-1:0] mask, bit with_ev);
        logic [NM-1:0] rem = mask;
        while (rem != 0) begin
            for (int i = 1; i <= NM; i++) begin
                int j = (ml + i) % NM;
                if (rem[j]) begin
                    gr_q.push_back(j);
                    if (with_ev)
                        foreach (bq[j][n]) ev_q.push_back('{k: j, err: 1'b0, b: bq[j][n]});
                    rem[j] = 1'b0;
                    ml = j;
                    break;
                end
            end
        end
    endfunction

    function automatic void start_master(int k);
        active[k] = 1'b1;
        cur[k]    = bq[k].pop_front();
        drive_all();
    endfunction

    function automatic void abort_master(int k);
        active[k] = 1'b0;
        bq[k].delete();
        drive_all();
    endfunction

    function automatic bit any_active();
        for (int k = 0; k < NM; k++) if (active[k]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic cycle();
        @(negedge clk);
        samp_ack = m_ack_o; samp_err = m_err_o; samp_busy = busy_o;
        samp_stb = s_stb_o; samp_cyc = s_cyc_o; samp_dat1 = m_dat_o[DW +: DW];
        @(posedge clk); #1;
        for (int k = 0; k < NM; k++)
            if (active[k] && samp_ack[k]) begin
                if (bq[k].size() == 0) active[k] = 1'b0;
                else cur[k] = bq[k].pop_front();
            end
        drive_all();
    endtask

    task automatic run_until_idle(string nm);
        int n = 0;
        while (any_active() && n < 400) begin cycle(); n++; end
        chk(nm, 64'(any_active()), 0);
        cycle(); cycle();
    endtask

    // Slave: acks after `lat` consecutive waiting cycles, read data derived from address.
    initial begin
        int  w = 0;
        bit  stbw, ackw;
        s_ack_i = 1'b0; s_dat_i = '0;
        forever begin
            @(negedge clk);
            stbw = s_cyc_o && s_stb_o; ackw = s_ack_i;
            @(posedge clk); #2;
            if (ackw || !stbw) w = 0; else w++;
            if (force_ack) begin
                s_ack_i = 1'b1; s_dat_i = 32'hBAD0_0000;
            end else if (smode != NEVER && ((lat == 0) ? (s_cyc_o && s_stb_o) : (w >= lat))) begin
                s_ack_i = 1'b1; s_dat_i = sfun(s_adr_o);
                if (smode == RAND) lat = $urandom_range(0, 3);
            end else begin
                s_ack_i = 1'b0; s_dat_i = $urandom;
            end
        end
    end

    // Monitor: reset state, grant protocol rules, scoreboard pops on grant rise and responses.
    initial begin
        logic [NM-1:0] pg = '0, pc = '0;
        bit pv = 1'b0;
        int g;
        ev_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_grant", 64'(grant_o), 0);
                chk("rst_busy", 64'(busy_o), 0);
                chk("rst_sbus", {s_cyc_o, s_stb_o, s_we_o}, 0);
                chk("rst_resp", {m_ack_o, m_err_o}, 0);
                pv = 1'b0;
            end else begin
                g = 0;
                for (int k = 0; k < NM; k++) if (grant_o[k]) g = k;
                chk("grant_onehot", {31'd0, busy_o, 32'(($countones(grant_o) == (busy_o ? 1 : 0)))}, {31'd0, (grant_o != 0), 32'd1});
                if (pv) begin
                    if (pg == 0) begin
                        if (|pc) chk("arb_latency", 64'(grant_o != 0), 1);
                    end else begin
                        for (int k = 0; k < NM; k++)
                            if (pg[k]) begin
                                if (pc[k]) chk("grant_hold", 64'(grant_o), 64'(pg));
                                else       chk("grant_release", 64'(grant_o), 0);
                            end
                    end
                end
                if ((!pv || pg == 0) && grant_o != 0) begin
                    if (gr_q.size() == 0) chk("unexpected_grant", 64'(grant_o), 0);
                    else chk("grant_order", 64'(grant_o), 64'(1 << gr_q.pop_front()));
                end
                if (grant_o == 0) begin
                    chk("idle_sbus", {s_cyc_o, s_stb_o, s_we_o, s_sel_o}, 0);
                    chk("idle_sadr", 64'(s_adr_o), 0);
                    chk("idle_resp", {m_ack_o, m_err_o}, 0);
                end else if (m_err_o == 0) begin
                    chk("s_cyc_follow", 64'(s_cyc_o), 64'(m_cyc[g]));
                    chk("s_adr_route", 64'(s_adr_o), 64'(m_adr[g*AW +: AW]));
                end
                if (m_ack_o != 0 || m_err_o != 0) begin
                    if (ev_q.size() == 0) chk("unexpected_resp", {m_ack_o, m_err_o}, 0);
                    else begin
                        e = ev_q.pop_front();
                        chk("resp_adr", 64'(s_adr_o), 64'(e.b.adr));
                        if (e.err) begin
                            chk("err_vec", {m_ack_o, m_err_o}, {4'd0, 4'(1 << e.k)});
                            chk("err_bus_low", {s_cyc_o, s_stb_o}, 0);
                        end else begin
                            chk("ack_vec", {m_ack_o, m_err_o}, {4'(1 << e.k), 4'd0});
                            chk("rdata", 64'(m_dat_o[e.k*DW +: DW]), 64'(sfun(e.b.adr)));
                            chk("rdata_bcast", 64'(m_dat_o[((e.k+1)%NM)*DW +: DW]), 64'(sfun(e.b.adr)));
                            chk("wr_ctl", {s_we_o, s_sel_o}, {e.b.we, e.b.sel});
                            if (e.b.we) chk("wdata", 64'(s_dat_o), 64'(e.b.wdat));
                        end
                    end
                end
                pv = 1'b1; pg = grant_o; pc = m_cyc;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [NM-1:0] mask;
        int n;
        for (int k = 0; k < NM; k++) active[k] = 1'b0;
        drive_all();
        force_ack = 1'b1;

        // All four request from reset release; acks during reset must be discarded.
        for (int k = 0; k < NM; k++) queue_burst(k, 1 + (k % 2));
        plan(4'b1111, 1'b1);
        for (int k = 0; k < NM; k++) start_master(k);
        cycle(); cycle(); cycle();
        force_ack = 1'b0;
        cycle();
        rst_n = 1'b1;
        run_until_idle("rr_all_done");
        queue_burst(0, 1); plan(4'b0001, 1'b1); start_master(0);
        run_until_idle("rr_wrap_done");

        // Burst on master 2 is not preempted by master 0.
        queue_burst(2, 4); queue_burst(0, 1);
        plan(4'b0100, 1'b1); plan(4'b0001, 1'b1);
        start_master(2); cycle(); cycle(); start_master(0);
        run_until_idle("burst_done");

        // Read data routing.
        queue_burst(1, 1);
        bq[1][0].adr = 32'hDEADBEEF ^ 32'h5A5A_5A5A; bq[1][0].we = 1'b0;
        plan(4'b0010, 1'b1); start_master(1);
        n = 0;
        while (active[1] && n < 50) begin
            cycle(); n++;
            if (samp_ack != 0) begin
                chk("read_ack_vec", 64'(samp_ack), 64'(4'b0010));
                chk("read_data", 64'(samp_dat1), 64'(32'hDEADBEEF));
            end
        end
        run_until_idle("read_done");

        // Ack exactly at the timeout limit, then one cycle earlier: no err.
        smode = FIXED; lat = TO;
        queue_burst(1, 2); plan(4'b0010, 1'b1); start_master(1);
        run_until_idle("ack_at_limit_done");
        lat = TO - 1;
        queue_burst(2, 1); plan(4'b0100, 1'b1); start_master(2);
        run_until_idle("ack_before_limit_done");

        // Slave never acks: err every TO+1 cycles with the bus strobe suppressed.
        smode = NEVER;
        queue_burst(3, 1); plan(4'b1000, 1'b0);
        for (int i = 0; i < 3; i++) ev_q.push_back('{k: 3, err: 1'b1, b: bq[3][0]});
        start_master(3);
        n = 0;
        do begin cycle(); n++; end while (!samp_busy && n < 20);
        chk("timeout_grant", 64'(samp_busy), 1);
        for (int c = 1; c <= 3 * (TO + 1); c++) begin
            if (c > 1) cycle();
            chk("timeout_err_timing", 64'(samp_err[3]), 64'(c % (TO + 1) == 0));
            if (c % (TO + 1) == 0) chk("timeout_bus_low", {samp_cyc, samp_stb}, 0);
        end
        abort_master(3);
        cycle(); cycle();

        // Reset mid-burst drops the bus immediately; master 0 wins afterwards.
        queue_burst(1, 2); plan(4'b0010, 1'b0); start_master(1);
        n = 0;
        do begin cycle(); n++; end while (!samp_busy && n < 20);
        cycle(); cycle();
        #2;
        chk("pre_reset_cyc", 64'(s_cyc_o), 1);
        rst_n = 1'b0;
        #1;
        chk("reset_async_bus", {s_cyc_o, s_stb_o, busy_o}, 0);
        abort_master(1);
        force_ack = 1'b1;
        smode = RAND; ml = NM - 1;
        mask = 4'b1011;
        for (int k = 0; k < NM; k++) if (mask[k]) queue_burst(k, 2);
        plan(mask, 1'b1);
        for (int k = 0; k < NM; k++) if (mask[k]) start_master(k);
        cycle(); cycle();
        force_ack = 1'b0;
        cycle();
        rst_n = 1'b1;
        run_until_idle("post_reset_done");

        // Random request sets and burst lengths.
        for (int r = 0; r < 15; r++) begin
            mask = NM'($urandom_range(1, (1 << NM) - 1));
            for (int k = 0; k < NM; k++) if (mask[k]) queue_burst(k, $urandom_range(1, 3));
            plan(mask, 1'b1);
            for (int k = 0; k < NM; k++) if (mask[k]) start_master(k);
            run_until_idle("random_round_done");
        end

        chk("resp_queue_drained", 64'(ev_q.size()), 0);
        chk("grant_queue_drained", 64'(gr_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
